conv_requant_packer: RTL and testbench
======================================

# conv_requant_packer

Downstream stage of the conv array and upstream of the fully-connected unit. It accepts one beat of CNN_COUNT 32-bit conv results per handshake and serialises the beat one channel per cycle. Each channel is requantised to DATA_WIDTH bits: rounding arithmetic shift, optional ReLU, then signed saturation. The quantised values are packed into LANES-wide operand vectors presented to the FC unit over a valid/ready handshake.

## Interface
Parameters:
- CNN_COUNT, 3: conv instances, i.e. results per input beat
- LANES, 10: operands per FC vector
- DATA_WIDTH, 8: quantised operand width, signed two's complement

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- conv_result  in  [CNN_COUNT][32]  signed conv accumulator outputs
- conv_valid  in  1  conv_result valid this cycle
- conv_ready  out  1  block can capture a beat; drives conv out_accepting_values
- shift  in  5  right-shift amount, 0..31; sampled at beat capture
- relu_en  in  1  clamp negatives to 0; sampled at beat capture
- flush  in  1  single-cycle pulse: emit any partial vector
- fc_operands  out  [LANES][DATA_WIDTH]  packed vector; lane 0 is the first value written
- fc_count  out  $clog2(LANES+1)  number of valid lanes in fc_operands, 1..LANES
- fc_valid  out  1  vector held in output register
- fc_ready  in  1  FC unit accepts the vector
- idle  out  1  holding register empty, fill==0, output empty, no flush pending

## Operation
- Holding register: captures conv_result, shift and relu_en when conv_valid && conv_ready.
- conv_ready = holding register empty. This is registered state only; there is no combinational path from conv_valid.
- Drain FSM has two states:
  - HOLD_EMPTY -> DRAIN on capture, with ch=0.
  - In DRAIN, one channel per cycle is written into the packer at lane index fill, in order ch=0..CNN_COUNT-1. The write happens only when the packer is not stalled.
  - After ch=CNN_COUNT-1 is written, DRAIN -> HOLD_EMPTY.
- Requantisation per channel, on a 33-bit signed intermediate:
  - r = x if shift==0, else (x + (1<<(shift-1))) >>> shift.
  - If relu_en && r<0, then r=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Packer:
  - fill counts 0..LANES-1.
  - The write making fill==LANES completes the vector. fill and the ch index wrap independently, so beats may straddle vectors (LANES=10, CNN_COUNT=3: the 4th beat's ch0 ends vector 0, and ch1 becomes lane 0 of vector 1).
- Output register:
  - A completed vector moves to fc_operands with fc_count=LANES and fc_valid=1 in the same edge as the completing write, with fill reset to 0.
  - This move requires the output register to be empty or to be accepted (fc_valid && fc_ready) in that cycle. Otherwise the packer stalls: the completing write is held, and ch and fill do not advance.
- Flush:
  - flush sets flush_pending; a pulse arriving while pending is absorbed.
  - flush_pending is serviced when the FSM is in HOLD_EMPTY and the output register is free (empty or accepted this cycle). If fill>0, the partial vector is emitted with fc_count=fill, unused lanes are 0, and fill is set to 0. If fill==0, nothing is emitted.
  - flush_pending clears when serviced.
  - conv_ready is forced low while flush_pending, so no beat is captured ahead of the flush.
- fc_operands and fc_count are stable while fc_valid && !fc_ready.

## Timing
- Reset values: conv_ready=1, fc_valid=0, fc_operands=0, fc_count=0, idle=1. Internally fill=0, ch=0, flush_pending=0, holding register empty.
- Reset mid-operation discards any partial vector, held beat, and pending flush.
- Latency with no stalls:
  - Beat captured at edge t; channel c written at edge t+1+c.
  - If that write completes a vector, fc_valid is high from edge t+1+c onward.
  - conv_ready returns high after edge t+CNN_COUNT, so sustained throughput is one beat per CNN_COUNT+1 cycles.
- An output transfer and a new vector load in the same cycle sustain full throughput; fc_valid stays high.
- A flush pulse in the same cycle as a beat capture: the beat is captured and drained first, then the flush is serviced.
- shift>=32 is impossible by width.

## Test plan
- shift=0, relu_en=0, 4 beats {1,2,3},{4,5,6},{7,8,9},{10,11,12}, fc_ready=1 -> one vector of lanes 1..10 with fc_count=10; then fill=2 holding 11,12.
- Then flush pulse -> vector {11,12,0,...} with fc_count=2; idle=1 afterwards.
- shift=4, inputs {24, -24, 1000}, relu_en=0 -> {2, -1, 63}. Same inputs with relu_en=1 -> {2, 0, 63}. shift=0, inputs {200, -300} -> saturate to {127, -128}.
- fc_ready=0 with a full vector held, keep sending beats -> the packer stalls at the completing write, conv_ready stays low, and no lane value is lost or reordered when fc_ready rises.
- Flush with fill==0 -> no fc_valid pulse. Flush during DRAIN -> the partial vector includes all channels of the in-flight beat.
- Assert reset while in DRAIN with fill=7 and fc_valid=1 -> next cycle all outputs are at reset values and a fresh beat lands in lane 0.

Source files
------------

// File: rtl/conv_requant_packer.sv
// Requantises CNN_COUNT conv results per beat, one channel per cycle, and packs
// the DATA_WIDTH results into LANES-wide vectors for the FC unit.
module conv_requant_packer #(
    parameter int CNN_COUNT  = 3,
    parameter int LANES      = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [CNN_COUNT-1:0][31:0]           conv_result,
    input  logic                                 conv_valid,
    output logic                                 conv_ready,
    input  logic [4:0]                           shift,
    input  logic                                 relu_en,
    input  logic                                 flush,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     fc_operands,
    output logic [$clog2(LANES+1)-1:0]           fc_count,
    output logic                                 fc_valid,
    input  logic                                 fc_ready,
    output logic                                 idle
);
    localparam int CW   = $clog2(LANES + 1);
    localparam int CHW  = (CNN_COUNT > 1) ? $clog2(CNN_COUNT) : 1;
    localparam int MAXV = 2 ** (DATA_WIDTH - 1) - 1;
    localparam int MINV = -(2 ** (DATA_WIDTH - 1));

    typedef enum logic [0:0] {HOLD_EMPTY = 1'b0, DRAIN = 1'b1} state_t;

    state_t                              state_q, state_d;
    logic [CHW-1:0]                      ch_q, ch_d;
    logic [CNN_COUNT-1:0][31:0]          hold_data_q, hold_data_d;
    logic [4:0]                          hold_shift_q, hold_shift_d;
    logic                                hold_relu_q, hold_relu_d;
    logic [CW-1:0]                       fill_q, fill_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]    pack_q, pack_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [CW-1:0]                       out_count_q, out_count_d;
    logic                                out_valid_q, out_valid_d;
    logic                                flush_pend_q, flush_pend_d;

    logic                                capture_s;
    logic                                out_free_s;
    logic                                completing_s;
    logic                                stall_s;
    logic [DATA_WIDTH-1:0]               lane_val_s;

    // Rounding arithmetic shift on a 33-bit intermediate, optional ReLU, then saturation.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic [31:0] x,
                                                      input logic [4:0]  sh,
                                                      input logic        relu);
        logic signed [32:0] xe;
        logic signed [32:0] rnd;
        logic signed [32:0] r;
        xe = {x[31], x};
        if (sh == 5'd0) begin
            r = xe;
        end else begin
            rnd = 33'sd1 <<< (sh - 5'd1);
            r   = (xe + rnd) >>> sh;
        end
        if (relu && (r < 33'sd0)) begin
            r = 33'sd0;
        end else begin
            r = r;
        end
        if (r > 33'(MAXV)) begin
            return DATA_WIDTH'(MAXV);
        end else if (r < 33'(MINV)) begin
            return DATA_WIDTH'(MINV);
        end else begin
            return r[DATA_WIDTH-1:0];
        end
    endfunction

    assign conv_ready   = (state_q == HOLD_EMPTY) && !flush_pend_q;
    assign capture_s    = conv_valid && conv_ready;
    assign out_free_s   = !out_valid_q || fc_ready;
    assign completing_s = (fill_q == CW'(LANES - 1));
    assign stall_s      = completing_s && !out_free_s;
    assign lane_val_s   = requant(hold_data_q[ch_q], hold_shift_q, hold_relu_q);

    assign fc_operands  = out_data_q;
    assign fc_count     = out_count_q;
    assign fc_valid     = out_valid_q;
    assign idle         = (state_q == HOLD_EMPTY) && (fill_q == '0) && !out_valid_q && !flush_pend_q;

    // Next-state: beat capture, channel drain into the packer, vector hand-off and flush service.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        hold_data_d  = hold_data_q;
        hold_shift_d = hold_shift_q;
        hold_relu_d  = hold_relu_q;
        fill_d       = fill_q;
        pack_d       = pack_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_valid_d  = out_valid_q;
        flush_pend_d = flush_pend_q;

        if (out_valid_q && fc_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (flush) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_q;
        end

        case (state_q)
            HOLD_EMPTY: begin
                if (capture_s) begin
                    hold_data_d  = conv_result;
                    hold_shift_d = shift;
                    hold_relu_d  = relu_en;
                    ch_d         = '0;
                    state_d      = DRAIN;
                end else if (flush_pend_q && out_free_s) begin
                    // Servicing clears the pending flag even if another pulse lands now.
                    flush_pend_d = 1'b0;
                    if (fill_q != '0) begin
                        out_data_d  = pack_q;
                        out_count_d = fill_q;
                        out_valid_d = 1'b1;
                        pack_d      = '0;
                        fill_d      = '0;
                    end else begin
                        fill_d = fill_q;
                    end
                end else begin
                    state_d = HOLD_EMPTY;
                end
            end
            DRAIN: begin
                if (stall_s) begin
                    state_d = DRAIN;
                end else begin
                    pack_d[fill_q] = lane_val_s;
                    if (completing_s) begin
                        out_data_d  = pack_d;
                        out_count_d = CW'(LANES);
                        out_valid_d = 1'b1;
                        pack_d      = '0;
                        fill_d      = '0;
                    end else begin
                        fill_d = fill_q + CW'(1);
                    end
                    if (ch_q == CHW'(CNN_COUNT - 1)) begin
                        ch_d    = '0;
                        state_d = HOLD_EMPTY;
                    end else begin
                        ch_d = ch_q + CHW'(1);
                    end
                end
            end
            default: begin
                state_d = HOLD_EMPTY;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HOLD_EMPTY;
            ch_q         <= '0;
            hold_data_q  <= '0;
            hold_shift_q <= 5'd0;
            hold_relu_q  <= 1'b0;
            fill_q       <= '0;
            pack_q       <= '0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            hold_data_q  <= hold_data_d;
            hold_shift_q <= hold_shift_d;
            hold_relu_q  <= hold_relu_d;
            fill_q       <= fill_d;
            pack_q       <= pack_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end
endmodule

// File: tb/tb_conv_requant_packer.sv
// Scoreboard bench: a list-level model of requantise-and-pack predicts every FC vector,
// and a monitor compares each accepted vector against the head of the expected queue.
module tb_conv_requant_packer;
    localparam int CNN_COUNT  = 3;
    localparam int LANES      = 10;
    localparam int DATA_WIDTH = 8;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] vec_t;

    logic                        clock;
    logic                        reset;
    logic [CNN_COUNT-1:0][31:0]  conv_result;
    logic                        conv_valid;
    logic                        conv_ready;
    logic [4:0]                  shift;
    logic                        relu_en;
    logic                        flush;
    vec_t                        fc_operands;
    logic [3:0]                  fc_count;
    logic                        fc_valid;
    logic                        fc_ready;
    logic                        idle;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_v[$];
    int   exp_c[$];
    int   part[$];
    bit   rand_ready   = 1'b0;
    bit   fc_ready_dir = 1'b1;

    conv_requant_packer #(.CNN_COUNT(CNN_COUNT), .LANES(LANES), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clock(clock), .reset(reset), .conv_result(conv_result), .conv_valid(conv_valid),
        .conv_ready(conv_ready), .shift(shift), .relu_en(relu_en), .flush(flush),
        .fc_operands(fc_operands), .fc_count(fc_count), .fc_valid(fc_valid),
        .fc_ready(fc_ready), .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FC-side back-pressure: directed level or random per cycle.
    always @(negedge clock) begin
        fc_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fc_ready_dir;
    end

    // Reference: floor((x + 2^(s-1)) / 2^s), ReLU, clamp to the signed operand range.
    function automatic int qmodel(input longint x, input int s, input bit relu);
        longint r, d;
        if (s == 0) begin
            r = x;
        end else begin
            d = longint'(1) << s;
            r = x + d / 2;
            if (r >= 0) r = r / d;
            else        r = -((-r + d - 1) / d);
        end
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic push_vec(input int n);
        vec_t v = '0;
        for (int i = 0; i < n; i++) v[i] = 8'(part[i]);
        exp_v.push_back(v);
        exp_c.push_back(n);
    endtask

    task automatic model_beat(input logic signed [31:0] a, b, c, input int s, input bit relu);
        longint xs[3];
        xs[0] = a; xs[1] = b; xs[2] = c;
        for (int k = 0; k < CNN_COUNT; k++) begin
            part.push_back(qmodel(xs[k], s, relu));
            if (part.size() == LANES) begin
                push_vec(LANES);
                part.delete();
            end
        end
    endtask

    task automatic model_flush();
        if (part.size() > 0) push_vec(part.size());
        part.delete();
    endtask

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic send_beat(input logic signed [31:0] a, b, c, input int s, input bit relu,
                             input bit with_flush);
        int guard = 0;
        while (!conv_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 2000) begin
            check("conv_ready_timeout", 0, 1);
        end else begin
            conv_result[0] = a; conv_result[1] = b; conv_result[2] = c;
            shift = 5'(s); relu_en = relu; conv_valid = 1'b1; flush = with_flush;
            model_beat(a, b, c, s, relu);
            if (with_flush) model_flush();
            @(negedge clock);
            conv_valid = 1'b0;
            flush = 1'b0;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        model_flush();
        @(negedge clock);
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (!(idle && exp_v.size() == 0) && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        check(name, (guard < 1000) ? 1 : 0, 1);
    endtask

    // Monitor: compare every accepted vector with the head of the scoreboard.
    always @(negedge clock) begin
        #1;
        if (!reset && fc_valid && fc_ready) begin
            total++;
            if (exp_v.size() == 0) begin
                bad++;
                $display("FAIL unexpected_vector: got count %0d data %h, expected no vector", fc_count, fc_operands);
            end else begin
                vec_t ev;
                int   ec;
                ev = exp_v.pop_front();
                ec = exp_c.pop_front();
                if (fc_operands !== ev) begin
                    bad++;
                    $display("FAIL vector_data: got %h expected %h", fc_operands, ev);
                end
                total++;
                if (fc_count !== 4'(ec)) begin
                    bad++;
                    $display("FAIL vector_count: got %0d expected %0d", fc_count, ec);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset = 1'b1; conv_valid = 1'b0; conv_result = '0; shift = 5'd0;
        relu_en = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_conv_ready", conv_ready, 1);
        check("reset_fc_valid", fc_valid, 0);
        check("reset_fc_operands", (fc_operands == '0) ? 1 : 0, 1);
        check("reset_fc_count", fc_count, 0);
        check("reset_idle", idle, 1);
        reset = 1'b0;
        @(negedge clock);

        // Sequential values, one full vector then a two-lane flush.
        for (int b = 0; b < 4; b++) send_beat(3*b+1, 3*b+2, 3*b+3, 0, 1'b0, 1'b0);
        pulse_flush();
        wait_idle("idle_after_flush");
        check("idle_level", idle, 1);

        // Rounding, ReLU and saturation.
        send_beat(24, -24, 1000, 4, 1'b0, 1'b0);
        send_beat(24, -24, 1000, 4, 1'b1, 1'b0);
        send_beat(200, -300, 5, 0, 1'b0, 1'b0);
        pulse_flush();
        wait_idle("idle_after_quant");

        // Flush with nothing packed must not produce a vector.
        pulse_flush();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (fc_valid) seen = 1'b1;
        end
        check("empty_flush_no_valid", seen, 0);

        // Back-pressure: stall at the completing write of the second vector.
        fc_ready_dir = 1'b0;
        repeat (2) @(negedge clock);
        for (int b = 0; b < 7; b++) send_beat(100+3*b, 101+3*b, 102+3*b, 1, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        check("stall_conv_ready_low", conv_ready, 0);
        check("stall_fc_valid", fc_valid, 1);
        check("stall_fc_count", fc_count, 10);
        fc_ready_dir = 1'b1;
        send_beat(-7, 7, -1000, 2, 1'b1, 1'b0);
        pulse_flush();
        wait_idle("idle_after_stall");

        // Randomised beats, back-pressure and flushes (including flush on the capture cycle).
        rand_ready = 1'b1;
        for (int b = 0; b < 60; b++) begin
            logic signed [31:0] d[3];
            for (int k = 0; k < 3; k++) begin
                d[k] = $urandom();
                if ($urandom_range(0, 1) == 0) d[k] = $signed(32'($urandom_range(0, 4000))) - 32'sd2000;
            end
            send_beat(d[0], d[1], d[2], $urandom_range(0, 31) % (($urandom_range(0, 1) == 0) ? 6 : 32),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) pulse_flush();
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 5)) @(negedge clock);
        end
        rand_ready = 1'b0;
        fc_ready_dir = 1'b1;
        repeat (2) @(negedge clock);
        pulse_flush();
        wait_idle("idle_after_random");

        // Reset during DRAIN with fill=7 and a full vector held.
        fc_ready_dir = 1'b0;
        repeat (2) @(negedge clock);
        for (int b = 0; b < 6; b++) send_beat(20+b, 40+b, 60+b, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_fc_valid", fc_valid, 0);
        check("midreset_fc_count", fc_count, 0);
        check("midreset_fc_operands", (fc_operands == '0) ? 1 : 0, 1);
        check("midreset_conv_ready", conv_ready, 1);
        check("midreset_idle", idle, 1);
        reset = 1'b0;
        exp_v.delete(); exp_c.delete(); part.delete();
        fc_ready_dir = 1'b1;
        send_beat(5, 6, 7, 0, 1'b0, 1'b0);
        pulse_flush();
        wait_idle("idle_after_reset");

        check("scoreboard_empty", exp_v.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
